// File: rtl/dmem_arbiter.sv
// Data memory arbiter: shares a single-port synchronous-read memory between the
// CPU load/store path and a debug/loader port. The CPU normally wins. After
// MAX_CPU_WINS consecutive contested CPU grants, the debug port is given a slot.
module dmem_arbiter #(
  parameter int unsigned AW           = 8,
  parameter int unsigned DW           = 16,
  parameter int unsigned MAX_CPU_WINS = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_stall,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_rvalid,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_gnt,
  output logic [DW-1:0] dbg_rdata,
  output logic          dbg_rvalid,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {StIdle, StRdCpu, StRdDbg} state_e;

  localparam logic [3:0] MaxWins = 4'(MAX_CPU_WINS);

  state_e     state_q, state_d;
  logic [3:0] wins_q, wins_d;
  logic       cpu_gnt, dbg_win;

  // Grant decision: only in IDLE and never while reset is asserted.
  always_comb begin
    cpu_gnt = 1'b0;
    dbg_win = 1'b0;
    if (!reset && state_q == StIdle) begin
      if (cpu_req && dbg_req) begin
        dbg_win = (wins_q == MaxWins);
        cpu_gnt = !dbg_win;
      end else begin
        cpu_gnt = cpu_req;
        dbg_win = dbg_req;
      end
    end
  end

  // Next state, win counter, memory mux and requester outputs.
  always_comb begin
    state_d    = state_q;
    wins_d     = wins_q;
    mem_addr   = cpu_addr;
    mem_wdata  = '0;
    mem_we     = 1'b0;
    dbg_gnt    = 1'b0;
    cpu_rvalid = 1'b0;
    dbg_rvalid = 1'b0;
    cpu_rdata  = '0;
    dbg_rdata  = '0;

    // Counter tracks only unbroken contention; any idle debug cycle clears it.
    if (!dbg_req || dbg_win) begin
      wins_d = '0;
    end else if (cpu_gnt && wins_q != MaxWins) begin
      wins_d = wins_q + 4'd1;
    end

    if (cpu_gnt) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_we    = cpu_we;
    end else if (dbg_win) begin
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
      mem_we    = dbg_we;
      dbg_gnt   = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (cpu_gnt && !cpu_we) begin
          state_d = StRdCpu;
        end else if (dbg_win && !dbg_we) begin
          state_d = StRdDbg;
        end
      end
      StRdCpu: begin
        cpu_rvalid = !reset;
        state_d    = StIdle;
      end
      StRdDbg: begin
        dbg_rvalid = !reset;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (cpu_rvalid) cpu_rdata = mem_rdata;
    if (dbg_rvalid) dbg_rdata = mem_rdata;
  end

  // CPU proceeds only on an issued store or when its load data is returning.
  assign cpu_stall = cpu_req && !((cpu_gnt && cpu_we) || cpu_rvalid);

  // State and win counter registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      wins_q  <= '0;
    end else begin
      state_q <= state_d;
      wins_q  <= wins_d;
    end
  end

endmodule
